// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared MDU op encodings, sequencer state type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;
    localparam logic [2:0] MDU_MSUB  = 3'd6;
    localparam logic [2:0] MDU_MSUBU = 3'd7;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Every signed op has an even encoding.
    function automatic logic is_signed_op(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic [63:0] mac_combine(input logic [2:0]  op,
                                                input logic [63:0] hilo,
                                                input logic [63:0] prod);
        case (op)
            MDU_MADD, MDU_MADDU: return hilo + prod;
            MDU_MSUB, MDU_MSUBU: return hilo - prod;
            default:             return prod;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider
// Purpose  : Unsigned 1-bit-per-cycle restoring divider core.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_divider
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        kill_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);

    logic [31:0] rem_q, quo_q, dsr_q;
    logic [4:0]  cnt_q;
    logic        run_q;

    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] rem_d, quo_d;

    // The shifted partial remainder is always < 2*divisor, so a 32-bit
    // subtraction is exact whenever the trial succeeds.
    always_comb begin
        w_shift = {rem_q, quo_q[31]};
        w_ge    = (w_shift >= {1'b0, dsr_q});
        rem_d   = w_ge ? (w_shift[31:0] - dsr_q) : w_shift[31:0];
        quo_d   = {quo_q[30:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dsr_q <= divisor_i;
            cnt_q <= 5'(DIV_ITER - 1);
            run_q <= 1'b1;
        end else if (kill_i) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == 5'd0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

    // Results are presented during the final step so the controller can
    // register the fixed-up value on the same edge.
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;
    assign done_o      = run_q && (cnt_q == 5'd0);

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : EXE-stage multiply/divide sequencer issuing one HI/LO write.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [63:0] hilo_i,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

    localparam logic [1:0] MUL_CNT_INIT = 2'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    mdu_state_e  state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [63:0] hilo_q, prod_q, result_q;
    logic [1:0]  mul_cnt_q;
    logic        neg_q, rsign_q, dz_q;

    logic        w_accept, w_signed, w_div_done;
    logic [63:0] w_ma, w_mb, w_prod, w_div_res;
    logic [31:0] w_mag_a, w_mag_b, w_quo, w_rem, w_q_fix, w_r_fix;

    always_comb begin
        w_signed = is_signed_op(op);
        w_ma     = {{32{w_signed & src0[31]}}, src0};
        w_mb     = {{32{w_signed & src1[31]}}, src1};
        w_prod   = w_ma * w_mb;
        w_mag_a  = (w_signed & src0[31]) ? (32'd0 - src0) : src0;
        w_mag_b  = (w_signed & src1[31]) ? (32'd0 - src1) : src1;
    end

    mdu_divider u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (w_accept && is_div_op(op)),
        .kill_i      (flush),
        .dividend_i  (w_mag_a),
        .divisor_i   (w_mag_b),
        .quotient_o  (w_quo),
        .remainder_o (w_rem),
        .done_o      (w_div_done)
    );

    always_comb begin
        w_q_fix   = neg_q   ? (32'd0 - w_quo) : w_quo;
        w_r_fix   = rsign_q ? (32'd0 - w_rem) : w_rem;
        w_div_res = dz_q ? {a_q, 32'hFFFF_FFFF} : {w_r_fix, w_q_fix};
    end

    always_comb begin
        state_d  = state_q;
        w_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_accept = 1'b1;
                    if (is_div_op(op))     state_d = ST_DIV;
                    else if (MUL_LAT == 1) state_d = ST_DONE;
                    else                   state_d = ST_MUL;
                end
            end
            ST_MUL:  if (mul_cnt_q == 2'd0) state_d = ST_DONE;
            ST_DIV:  if (w_div_done)        state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            hilo_q    <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            mul_cnt_q <= '0;
            neg_q     <= 1'b0;
            rsign_q   <= 1'b0;
            dz_q      <= 1'b0;
        end else if (w_accept) begin
            op_q      <= op;
            a_q       <= src0;
            hilo_q    <= hilo_i;
            prod_q    <= w_prod;
            mul_cnt_q <= MUL_CNT_INIT;
            neg_q     <= w_signed & (src0[31] ^ src1[31]);
            rsign_q   <= w_signed & src0[31];
            dz_q      <= (src1 == 32'd0);
            // Single-cycle latency has no MUL state to accumulate in.
            if (MUL_LAT == 1 && !is_div_op(op)) begin
                result_q <= mac_combine(op, hilo_i, w_prod);
            end
        end else if (state_q == ST_MUL) begin
            if (mul_cnt_q == 2'd0) begin
                result_q <= mac_combine(op_q, hilo_q, prod_q);
            end else begin
                mul_cnt_q <= mul_cnt_q - 2'd1;
            end
        end else if (state_q == ST_DIV && w_div_done) begin
            result_q <= w_div_res;
        end
    end

    assign stall_req  = rst_n & (((state_q == ST_IDLE) & start & ~flush) |
                                 (state_q == ST_MUL) | (state_q == ST_DIV));
    assign busy       = (state_q != ST_IDLE);
    assign hilo_we    = (state_q == ST_DONE) & ~flush;
    assign hilo_wdata = hilo_we ? result_q : 64'd0;

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the EXE stage. It accepts HI/LO-class operations (MULT/MULTU, DIV/DIVU, MADD/MADDU, MSUB/MSUBU), runs a pipelined multiply or an iterative 1-bit-per-cycle restoring divide, and stalls EXE until the result is ready. On completion it issues a single-cycle HI/LO write. Single-cycle ALU ops (including MUL to a GPR) never reach this block.

## Interface
Parameters:
- MUL_LAT, default 2: cycles from acceptance to HI/LO write for multiply-class ops; legal range is 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  EXE holds a valid MDU op; stays high while EXE is stalled.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- src0  in  32  rs operand (dividend / multiplicand).
- src1  in  32  rt operand (divisor / multiplier).
- hilo_i  in  64  {HI,LO} after forwarding; sampled at acceptance.
- flush  in  1  exception/ERET flush; kills the in-flight op.
- stall_req  out  1  hold EXE and all earlier stages.
- busy  out  1  state is not IDLE.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hilo_wdata  out  64  {HI,LO} result; valid only while hilo_we=1.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset state is IDLE. All result and operand registers reset to 0.
- Acceptance:
  - An op is accepted only in IDLE when start=1 and flush=0.
  - Operands, op and hilo_i are latched.
  - Next state: MUL for op 0,1,4..7, or DONE directly if MUL_LAT=1. DIV for op 2,3.
- MUL: counter runs MUL_LAT-1 cycles, then DONE.
  - Signed ops (0,4,6) form a 64-bit two's-complement product. Unsigned ops (1,5,7) form a zero-extended product.
  - MADD/MADDU: hilo + product.
  - MSUB/MSUBU: hilo − product.
  - Both are mod 2^64.
- DIV: restoring division on operand magnitudes, 32 iterations, counter 31→0, then DONE.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0: LO=0xFFFFFFFF, HI=src0 (raw), with the same latency.
  - hilo_wdata = {remainder, quotient}.
- DONE:
  - hilo_we = ~flush, for one cycle.
  - Always returns to IDLE.
  - start in DONE is ignored, because it belongs to the retiring instruction.
- flush: any state goes to IDLE on the next edge, with no hilo_we (gated combinationally in DONE). A flush in IDLE blocks acceptance.
- rst_n low mid-operation: immediately IDLE, outputs 0, no write.

## Timing
- stall_req = (IDLE & start & ~flush) | MUL | DIV. It is combinational and 0 in DONE, so EXE advances at the end of DONE.
- Acceptance cycle = cycle 0.
- Multiply-class: hilo_we in cycle MUL_LAT; stall_req high for cycles 0..MUL_LAT-1.
- Divide: DIV occupies cycles 1..32, hilo_we in cycle 33; stall_req high for cycles 0..32.
- busy is registered, high from cycle 1 through DONE.
- Back-to-back ops: the earliest next acceptance is the cycle after DONE. Throughput is 1 op per MUL_LAT+1 or 34 cycles.
- hilo_we and hilo_wdata are outputs of DONE-state registers, except for the flush gating.

## Structure
- Shared package mdu_pkg holds:
  - the op encodings (MDU_MULT..MDU_MSUBU),
  - the state enum,
  - DIV_ITER = 32.
- The ID-stage decoder imports the same op constants.
- Sub-module mdu_divider, natural split:
  - iterative restoring core with its own load/step/count;
  - inputs: unsigned magnitudes;
  - outputs: quotient/remainder and a done pulse.
- The controller does the sign fix-up and owns the FSM.
- The multiply product is a registered pipeline inside mdu_ctrl.

## Test plan
- MULT src0=0xFFFFFFFD, src1=5, MUL_LAT=2 → stall_req high for cycles 0–1; hilo_we in cycle 2 with 0xFFFFFFFF_FFFFFFF1; busy low in cycle 3.
- DIVU 100/7 → hilo_we in cycle 33 with {HI=2, LO=14}. DIV 0xFFFFFFF9/2 → {0xFFFFFFFF, 0xFFFFFFFD}. DIV 0x80000000/0xFFFFFFFF → {0, 0x80000000}.
- MADD hilo_i=0x00000000_00000010, 3×4 → 0x00000000_0000001C. MSUBU hilo_i=0, 1×1 → 0xFFFFFFFF_FFFFFFFF.
- DIV with src1=0, src0=0x1234 → cycle 33 write {0x00001234, 0xFFFFFFFF}.
- Flush in cycle 10 of a DIV → IDLE in cycle 11, no hilo_we, stall_req 0. A new start in cycle 11 is accepted, and its result is correct.
- start held through DONE → exactly one hilo_we. Reset asserted in cycle 5 of a DIV → all outputs 0 immediately, no write after release.
